// File: rtl/flex_cnt_pkg.sv
// Shared constants and helpers for the flex counter family.
//
// Contents:
//   CNT_UP / CNT_DOWN    : values of the per-channel up_down input
//   MODE_WRAP / MODE_SAT : values of the per-channel sat_mode input
//   terminal_val()       : the terminal value T for a direction and rollover R
package flex_cnt_pkg;

  localparam logic CNT_UP    = 1'b1;
  localparam logic CNT_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Up-counting terminates at R and down-counting terminates at 1, because
  // the legal range is 1..R. Widths are at most 32 bits, so callers
  // zero-extend their operands to 32 bits.
  function automatic logic [31:0] terminal_val(input logic up, input logic [31:0] r);
    return (up == CNT_UP) ? r : 32'd1;
  endfunction

endpackage

// File: rtl/flex_counter_ch.sv
// A single flex counter channel.
//
// Ports:
//   clk, n_rst      : clock (rising edge) and asynchronous active-low reset
//   clear           : synchronous clear (highest priority)
//   load, load_val  : synchronous load of any value, including values above rval
//   en              : effective count enable (the cascade gating is done outside)
//   up              : 1 = count up, 0 = count down
//   sat             : 1 = saturate at the terminal value, 0 = wrap
//   rval            : rollover value R; R == 0 makes the channel inert
//   count           : registered count
//   flag            : registered, high while count equals the terminal value
//   wrap_pulse      : registered copy of wrap_evt, high for one cycle
//   wrap_evt        : combinational, high when this edge wraps the count
module flex_counter_ch
  import flex_cnt_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clear,
  input  logic         en,
  input  logic         up,
  input  logic         sat,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] rval,
  output logic [W-1:0] count,
  output logic         flag,
  output logic         wrap_pulse,
  output logic         wrap_evt
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] next_count;
  logic         next_flag;

  always_comb begin
    next_count = count;
    wrap_evt   = 1'b0;
    if (clear) begin
      next_count = '0;
    end else if (load) begin
      next_count = load_val;
    end else if (en && (rval != '0)) begin
      if (up == CNT_UP) begin
        // count >= R never increments, so the add cannot overflow.
        if (count < rval) begin
          next_count = count + ONE;
        end else if (sat == MODE_SAT) begin
          next_count = rval;
        end else begin
          next_count = ONE;
          wrap_evt   = 1'b1;
        end
      end else begin
        if ((count == '0) || (count > rval)) begin
          // Out-of-range start re-enters the range at the top, silently.
          next_count = rval;
        end else if (count == ONE) begin
          if (sat == MODE_WRAP) begin
            next_count = rval;
            wrap_evt   = 1'b1;
          end
        end else begin
          next_count = count - ONE;
        end
      end
    end
  end

  // Flag follows the next count so that flag and count update together.
  always_comb begin
    next_flag = 1'b0;
    if (!clear) begin
      next_flag = (32'(next_count) == terminal_val(up, 32'(rval))) && (rval != '0);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count      <= '0;
      flag       <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      count      <= next_count;
      flag       <= next_flag;
      wrap_pulse <= wrap_evt;
    end
  end

endmodule

// File: rtl/multi_flex_counter.sv
// Multi-channel flex counter with optional ripple-carry cascade.
//
// Parameters:
//   NUM_CNT_BITS : width of each channel's count / load / rollover value
//   NUM_CH       : number of channels (1..8)
//   CASCADE      : 1 = channel i>0 advances only on channel i-1's wrap event
//
// Ports (all per-channel vectors are indexed by channel):
//   clk, n_rst    : clock (rising edge), asynchronous active-low reset
//   clear         : synchronous clear
//   count_enable  : count enable
//   up_down       : 1 = up, 0 = down
//   sat_mode      : 1 = saturate, 0 = wrap
//   load          : synchronous load strobe
//   load_val      : value loaded on load
//   rollover_val  : rollover value R
//   count_out     : registered count
//   rollover_flag : registered, high while count equals the terminal value
//   wrap_pulse    : registered one-cycle pulse following a wrap
module multi_flex_counter
  import flex_cnt_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4,
  parameter int NUM_CH       = 2,
  parameter int CASCADE      = 0
) (
  input  logic                                 clk,
  input  logic                                 n_rst,
  input  logic [NUM_CH-1:0]                    clear,
  input  logic [NUM_CH-1:0]                    count_enable,
  input  logic [NUM_CH-1:0]                    up_down,
  input  logic [NUM_CH-1:0]                    sat_mode,
  input  logic [NUM_CH-1:0]                    load,
  input  logic [NUM_CH-1:0][NUM_CNT_BITS-1:0]  load_val,
  input  logic [NUM_CH-1:0][NUM_CNT_BITS-1:0]  rollover_val,
  output logic [NUM_CH-1:0][NUM_CNT_BITS-1:0]  count_out,
  output logic [NUM_CH-1:0]                    rollover_flag,
  output logic [NUM_CH-1:0]                    wrap_pulse
);

  localparam logic CASCADE_ON = (CASCADE != 0);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_en;
    logic ch_evt;

    if (i == 0) begin : g_first
      assign ch_en = count_enable[i];
    end else begin : g_next
      // The previous wrap event is combinational, so the whole chain
      // advances on a single edge.
      assign ch_en = count_enable[i] & (~CASCADE_ON | g_ch[i-1].ch_evt);
    end

    if (i == NUM_CH - 1) begin : g_last
      // The last channel's wrap event has no downstream consumer.
      logic evt_unused;
      assign evt_unused = ch_evt;
    end

    flex_counter_ch #(
      .W(NUM_CNT_BITS)
    ) u_ch (
      .clk        (clk),
      .n_rst      (n_rst),
      .clear      (clear[i]),
      .en         (ch_en),
      .up         (up_down[i]),
      .sat        (sat_mode[i]),
      .load       (load[i]),
      .load_val   (load_val[i]),
      .rval       (rollover_val[i]),
      .count      (count_out[i]),
      .flag       (rollover_flag[i]),
      .wrap_pulse (wrap_pulse[i]),
      .wrap_evt   (ch_evt)
    );
  end

endmodule

// File: tb/tb_multi_flex_counter.sv
// Directed bench for multi_flex_counter: one independent-channel instance
// and one cascaded instance, both 2 channels x 4 bits.
module tb_multi_flex_counter;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  // Independent-channel instance
  logic [1:0]      clear, ce, ud, sm, ld;
  logic [1:0][3:0] lv, rv, co;
  logic [1:0]      rf, wp;

  // Cascaded instance
  logic [1:0]      c_clear, c_ce, c_ud, c_sm, c_ld;
  logic [1:0][3:0] c_lv, c_rv, c_co;
  logic [1:0]      c_rf, c_wp;

  int total = 0;
  int bad   = 0;

  multi_flex_counter #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(0)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .count_enable(ce), .up_down(ud),
    .sat_mode(sm), .load(ld), .load_val(lv), .rollover_val(rv),
    .count_out(co), .rollover_flag(rf), .wrap_pulse(wp)
  );

  multi_flex_counter #(.NUM_CNT_BITS(4), .NUM_CH(2), .CASCADE(1)) dut_c (
    .clk(clk), .n_rst(n_rst), .clear(c_clear), .count_enable(c_ce), .up_down(c_ud),
    .sat_mode(c_sm), .load(c_ld), .load_val(c_lv), .rollover_val(c_rv),
    .count_out(c_co), .rollover_flag(c_rf), .wrap_pulse(c_wp)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ch0(input string tag, input int c, input int f, input int p);
    check_val({tag, ".count"}, 32'(co[0]), 32'(c));
    check_val({tag, ".flag"},  32'(rf[0]), 32'(f));
    check_val({tag, ".pulse"}, 32'(wp[0]), 32'(p));
  endtask

  task automatic check_ch1(input string tag, input int c, input int f, input int p);
    check_val({tag, ".count"}, 32'(co[1]), 32'(c));
    check_val({tag, ".flag"},  32'(rf[1]), 32'(f));
    check_val({tag, ".pulse"}, 32'(wp[1]), 32'(p));
  endtask

  int seq_up   [7] = '{1, 2, 3, 4, 5, 1, 2};
  int seq_dn   [4] = '{2, 1, 1, 1};
  int seq_dn_f [4] = '{0, 1, 1, 1};
  int seq_su   [4] = '{2, 3, 4, 4};
  int seq_su_f [4] = '{0, 0, 1, 1};
  int cas_c0   [18] = '{1,2,3,1,2,3,1,2,3,1,2,3,1,2,3,1,2,3};
  int cas_c1   [18] = '{0,0,0,1,1,1,2,2,2,1,1,1,2,2,2,1,1,1};
  int cas_p1   [18] = '{0,0,0,0,0,0,0,0,0,1,0,0,0,0,0,1,0,0};
  int cas_p0   [18] = '{0,0,0,1,0,0,1,0,0,1,0,0,1,0,0,1,0,0};
  int cas_f1   [18] = '{0,0,0,0,0,0,1,1,1,0,0,0,1,1,1,0,0,0};

  initial begin
    clear = '0; ce = '0; ud = '0; sm = '0; ld = '0; lv = '0; rv = '0;
    c_clear = '0; c_ce = '0; c_ud = '0; c_sm = '0; c_ld = '0; c_lv = '0; c_rv = '0;

    // ---- reset ----
    tick(); tick();
    check_val("rst.count", 32'(co), 32'd0);
    check_val("rst.flag",  32'(rf), 32'd0);
    check_val("rst.pulse", 32'(wp), 32'd0);
    check_val("rst.c_count", 32'(c_co), 32'd0);
    n_rst = 1'b1;

    // ---- legacy up/wrap on ch0, R=5 ----
    rv[0] = 4'd5; ud[0] = 1'b1; sm[0] = 1'b0; ce[0] = 1'b1;
    check_ch0("up.start", 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      tick();
      check_ch0($sformatf("up.e%0d", k), seq_up[k], (seq_up[k] == 5) ? 1 : 0, (k == 5) ? 1 : 0);
    end
    tick();  // count 3

    // ---- asynchronous reset mid-count ----
    #3;
    n_rst = 1'b0;
    #1;
    check_val("arst.count", 32'(co), 32'd0);
    check_val("arst.flag",  32'(rf), 32'd0);
    check_val("arst.pulse", 32'(wp), 32'd0);
    ce = '0;
    #1;
    n_rst = 1'b1;
    tick();
    check_ch0("arst.hold", 0, 0, 0);

    // ---- down / saturate on ch1, R=4, load 3 ----
    rv[1] = 4'd4; ud[1] = 1'b0; sm[1] = 1'b1; lv[1] = 4'd3; ld[1] = 1'b1;
    tick();
    check_ch1("dsat.load", 3, 0, 0);
    ld[1] = 1'b0; ce[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_ch1($sformatf("dsat.e%0d", k), seq_dn[k], seq_dn_f[k], 0);
    end
    ud[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_ch1($sformatf("usat.e%0d", k), seq_su[k], seq_su_f[k], 0);
    end
    ce[1] = 1'b0;

    // ---- priority clear > load > en on ch0 ----
    clear[0] = 1'b1; ld[0] = 1'b1; lv[0] = 4'd7; ce[0] = 1'b1;
    tick();
    check_ch0("prio.clear", 0, 0, 0);
    clear[0] = 1'b0;
    tick();
    check_ch0("prio.load", 7, 0, 0);
    ld[0] = 1'b0;
    tick();
    check_ch0("prio.above_r", 1, 0, 1);
    ce[0] = 1'b0;

    // ---- R=0: inert, but clear and load still act ----
    rv[0] = 4'd0; clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0; ce[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_ch0($sformatf("r0.e%0d", k), 0, 0, 0);
    end
    ld[0] = 1'b1; lv[0] = 4'd3;
    tick();
    check_ch0("r0.load", 3, 0, 0);
    ld[0] = 1'b0;
    tick();
    check_ch0("r0.hold", 3, 0, 0);
    ce[0] = 1'b0;

    // ---- load 12 with R=5, up, wrap ----
    rv[0] = 4'd5; ud[0] = 1'b1; sm[0] = 1'b0; ld[0] = 1'b1; lv[0] = 4'd12;
    tick();
    check_ch0("ld12.load", 12, 0, 0);
    ld[0] = 1'b0; ce[0] = 1'b1;
    tick();
    check_ch0("ld12.wrap", 1, 0, 1);
    ce[0] = 1'b0;

    // ---- down from 0 with R=9 ----
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0; rv[0] = 4'd9; ud[0] = 1'b0; ce[0] = 1'b1;
    tick();
    check_ch0("dn0.first", 9, 0, 0);
    tick();
    check_ch0("dn0.second", 8, 0, 0);
    ce[0] = 1'b0;

    // ---- disable hold at terminal, R=5 up wrap ----
    clear[0] = 1'b1; rv[0] = 4'd5; ud[0] = 1'b1;
    tick();
    clear[0] = 1'b0; ce[0] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check_ch0("hold.reach", 5, 1, 0);
    ce[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_ch0($sformatf("hold.c%0d", k), 5, 1, 0);
    end
    ce[0] = 1'b1;
    tick();
    check_ch0("hold.reen", 1, 0, 1);
    ce[0] = 1'b0;
    tick();
    check_ch0("hold.once", 1, 0, 0);

    // ---- cascade: R0=3, R1=2, up, wrap ----
    c_rv[0] = 4'd3; c_rv[1] = 4'd2; c_ud = 2'b11; c_sm = 2'b00; c_ce = 2'b11;
    for (int k = 0; k < 18; k++) begin
      tick();
      check_val($sformatf("cas.c0.e%0d", k), 32'(c_co[0]), 32'(cas_c0[k]));
      check_val($sformatf("cas.p0.e%0d", k), 32'(c_wp[0]), 32'(cas_p0[k]));
      check_val($sformatf("cas.c1.e%0d", k), 32'(c_co[1]), 32'(cas_c1[k]));
      check_val($sformatf("cas.f1.e%0d", k), 32'(c_rf[1]), 32'(cas_f1[k]));
      check_val($sformatf("cas.p1.e%0d", k), 32'(c_wp[1]), 32'(cas_p1[k]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
